// File: rtl/obstacle_alert_scheduler_if.sv
// Sensor/speaker signal bundle shared by obstacle_alert_scheduler and whatever drives it.
// The master side owns enable and raw sensors; the slave side (the scheduler) owns the speaker outputs.
interface obstacle_alert_scheduler_if;
    logic       ena;
    logic [2:0] sensor_in;
    logic [2:0] spk_sel;
    logic       tone_out;
    logic [2:0] active_mask;
    logic       busy;

    modport master (
        output ena,
        output sensor_in,
        input  spk_sel,
        input  tone_out,
        input  active_mask,
        input  busy
    );

    modport slave (
        input  ena,
        input  sensor_in,
        output spk_sel,
        output tone_out,
        output active_mask,
        output busy
    );
endinterface

// File: rtl/obstacle_alert_scheduler.sv
// Round-robin speaker sharing for three obstacle sensors: synchronise, debounce, then grant
// each active channel a fixed dwell with its own tone, separated by silent gaps.
module obstacle_alert_scheduler #(
    parameter int CNT_W      = 16,
    parameter int DEB_CYCLES = 4,
    parameter int DWELL      = 1000,
    parameter int GAP        = 200,
    parameter int TONE_HP0   = 50,
    parameter int TONE_HP1   = 75,
    parameter int TONE_HP2   = 100
) (
    input logic                       clk,
    input logic                       rst_n,
    obstacle_alert_scheduler_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PLAY,
        ST_GAP
    } state_t;

    localparam logic [CNT_W-1:0] DEB_M1   = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] DWELL_M1 = CNT_W'(DWELL - 1);
    localparam logic [CNT_W-1:0] GAP_M1   = CNT_W'(GAP - 1);

    logic [2:0]            sync1_q, sync2_q;
    logic [2:0][CNT_W-1:0] deb_cnt_q, deb_cnt_d;
    logic [2:0]            mask_q, mask_d;
    state_t                state_q, state_d;
    logic [1:0]            grant_q, grant_d;
    logic [1:0]            rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]      timer_q, timer_d;
    logic [CNT_W-1:0]      phase_q, phase_d;
    logic                  tone_q, tone_d;
    logic [2:0]            spk_sel_q, spk_sel_d;
    logic                  busy_q, busy_d;
    logic [2:0]            pick;

    function automatic logic [1:0] mod3_add(input logic [1:0] a, input logic [1:0] b);
        logic [2:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= 3'd3) s = s - 3'd3;
        return s[1:0];
    endfunction

    // Scan from rr_ptr upward; iterating backwards lets the closest active channel win.
    function automatic logic [2:0] pick_grant(input logic [2:0] mask, input logic [1:0] ptr);
        logic [2:0] result;
        logic [1:0] idx;
        result = {1'b0, ptr};
        for (int k = 2; k >= 0; k--) begin
            idx = mod3_add(ptr, 2'(k));
            if (mask[idx]) result = {1'b1, idx};
        end
        return result;
    endfunction

    function automatic logic [CNT_W-1:0] hp_m1(input logic [1:0] g);
        case (g)
            2'd1:    return CNT_W'(TONE_HP1 - 1);
            2'd2:    return CNT_W'(TONE_HP2 - 1);
            default: return CNT_W'(TONE_HP0 - 1);
        endcase
    endfunction

    function automatic logic [2:0] onehot(input logic [1:0] g);
        case (g)
            2'd1:    return 3'b010;
            2'd2:    return 3'b100;
            default: return 3'b001;
        endcase
    endfunction

    always_comb begin
        deb_cnt_d = deb_cnt_q;
        mask_d    = mask_q;
        for (int i = 0; i < 3; i++) begin
            if (sync2_q[i] != mask_q[i]) begin
                if (deb_cnt_q[i] == DEB_M1) begin
                    mask_d[i]    = ~mask_q[i];
                    deb_cnt_d[i] = '0;
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
                end
            end else begin
                deb_cnt_d[i] = '0;
            end
        end
    end

    assign pick = pick_grant(mask_q, rr_ptr_q);

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        rr_ptr_d  = rr_ptr_q;
        timer_d   = timer_q;
        phase_d   = phase_q;
        tone_d    = tone_q;
        spk_sel_d = spk_sel_q;
        case (state_q)
            ST_IDLE: begin
                if (pick[2]) begin
                    state_d   = ST_PLAY;
                    grant_d   = pick[1:0];
                    spk_sel_d = onehot(pick[1:0]);
                    timer_d   = DWELL_M1;
                    phase_d   = '0;
                    tone_d    = 1'b0;
                end
            end
            ST_PLAY: begin
                // Dwell expiry and a dropped sensor both end the grant the same way.
                if (!mask_q[grant_q] || timer_q == '0) begin
                    state_d   = ST_GAP;
                    rr_ptr_d  = mod3_add(grant_q, 2'd1);
                    spk_sel_d = 3'b000;
                    tone_d    = 1'b0;
                    timer_d   = GAP_M1;
                    phase_d   = '0;
                end else begin
                    timer_d = timer_q - 1'b1;
                    if (phase_q == hp_m1(grant_q)) begin
                        tone_d  = ~tone_q;
                        phase_d = '0;
                    end else begin
                        phase_d = phase_q + 1'b1;
                    end
                end
            end
            ST_GAP: begin
                if (timer_q == '0) begin
                    if (pick[2]) begin
                        state_d   = ST_PLAY;
                        grant_d   = pick[1:0];
                        spk_sel_d = onehot(pick[1:0]);
                        timer_d   = DWELL_M1;
                        phase_d   = '0;
                        tone_d    = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                spk_sel_d = 3'b000;
                tone_d    = 1'b0;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            deb_cnt_q <= '0;
            mask_q    <= '0;
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            rr_ptr_q  <= '0;
            timer_q   <= '0;
            phase_q   <= '0;
            tone_q    <= 1'b0;
            spk_sel_q <= '0;
            busy_q    <= 1'b0;
        end else if (bus.ena) begin
            sync1_q   <= bus.sensor_in;
            sync2_q   <= sync1_q;
            deb_cnt_q <= deb_cnt_d;
            mask_q    <= mask_d;
            state_q   <= state_d;
            grant_q   <= grant_d;
            rr_ptr_q  <= rr_ptr_d;
            timer_q   <= timer_d;
            phase_q   <= phase_d;
            tone_q    <= tone_d;
            spk_sel_q <= spk_sel_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.spk_sel     = spk_sel_q;
    assign bus.tone_out    = tone_q;
    assign bus.active_mask = mask_q;
    assign bus.busy        = busy_q;

endmodule

// File: doc/obstacle_alert_scheduler.md
Name: obstacle_alert_scheduler

Overview:
Shares one speaker/tone driver among the three obstacle-sensor channels (left, centre, right). Each raw sensor is synchronised and debounced, then a round-robin scheduler grants the speaker to one active channel for a fixed dwell window with a channel-specific tone, followed by a silent gap. The user hears every active direction in turn instead of only the highest-priority one. Sits between the ui_in sensor pins and the uo_out speaker pins of the top level.

Parameters:
CNT_W, 16, width of dwell/gap/tone/debounce counters
DEB_CYCLES, 4, consecutive equal synchronised samples needed to change a debounced level (1..2^CNT_W-1)
DWELL, 1000, cycles a granted channel drives the speaker (1..2^CNT_W-1)
GAP, 200, silent cycles after every grant (1..2^CNT_W-1)
TONE_HP0, 50, tone half-period in cycles for channel 0 (>=1)
TONE_HP1, 75, tone half-period for channel 1 (>=1)
TONE_HP2, 100, tone half-period for channel 2 (>=1)

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous assert, active-low
ena  input  1  design enable; low = every register holds its value
sensor_in  input  3  raw LIDAR "object close" flags, bit i = channel i, asynchronous
spk_sel  output  3  one-hot granted channel, 000 when none
tone_out  output  1  square-wave tone for granted channel, 0 when none
active_mask  output  3  debounced sensor levels
busy  output  1  1 when FSM not in IDLE

Behaviour:
- Reset (rst_n=0, async): sync flops, debounce counters, active_mask, spk_sel, tone_out, busy, all counters = 0; rr_ptr = 0; state = IDLE. Takes effect immediately, including mid-PLAY/GAP.
- ena=0: no register updates (FSM, counters, sync, debounce frozen); outputs hold. Reset still acts.
- Sync: 2-flop synchroniser per bit -> s2[i].
- Debounce per channel: counter counts consecutive edges where s2[i] != active_mask[i]; reset to 0 when equal. On the edge where it reaches DEB_CYCLES, active_mask[i] flips, counter clears.
- Latency: raw rise held steady -> active_mask[i]=1 after DEB_CYCLES+2 edges; -> spk_sel from IDLE after DEB_CYCLES+3 edges.
- FSM states IDLE, PLAY, GAP.
- Grant selection: first set bit of active_mask scanning rr_ptr, rr_ptr+1, rr_ptr+2 (mod 3).
- IDLE: active_mask != 0 -> PLAY, spk_sel = one-hot grant, dwell counter loaded, tone phase counter = 0, tone_out = 0. Else stay.
- PLAY: spk_sel held exactly DWELL cycles. tone_out toggles every TONE_HPg cycles of the granted channel (period 2*TONE_HPg, first half low). After DWELL cycles -> GAP. rr_ptr <= (grant+1) mod 3 on leaving PLAY.
- PLAY abort: if active_mask[grant] falls, next edge -> GAP (spk_sel=000, tone_out=0), rr_ptr updated as above.
- GAP: spk_sel=000, tone_out=0 exactly GAP cycles; at end, if active_mask != 0 go straight to PLAY with new grant (no IDLE cycle), else IDLE.
- New sensors asserting during PLAY/GAP only affect the next grant; no preemption.
- busy = (state != IDLE), registered with state.
- All outputs registered; no combinational input-to-output path.
- Counters never wrap: parameters are bounded to fit CNT_W.

Test Plan:
- Params DEB_CYCLES=2, DWELL=8, GAP=3, HP0/1/2=1/2/3 for all. Reset: drive rst_n=0 mid-PLAY between edges -> spk_sel, tone_out, busy, active_mask = 0 immediately; after release with sensors 0, stay IDLE.
- Single channel: sensor_in=001 held -> active_mask=001 after 4 edges, spk_sel=001 after 5 edges for 8 cycles, tone_out 0,1,0,1,0,1,0,1; then 3 cycles 000; then 001 again.
- Round-robin: sensor_in=111 held -> grants 001,010,100,001 each 8 cycles, 3-cycle gaps; channel 2 tone 0,0,0,1,1,1,0,0.
- Glitch reject: 1-cycle pulse on sensor_in[1] -> active_mask stays 000, spk_sel stays 000, busy stays 0.
- Abort: channel 0 granted, sensor_in[0] drops at PLAY cycle 2 -> spk_sel=000 one edge after active_mask[0] falls; 3-cycle gap; if sensor_in=100 held, next grant 100.
- ena freeze: ena=0 for 5 cycles mid-PLAY -> spk_sel/tone_out hold; remaining dwell completes after ena=1 (total high time still 8 enabled cycles).
